// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared prescaled time base, edge/center-aligned counting
// and double-buffered settings that are applied only at period boundaries.
module pwm_multi #(
  parameter int WIDTH          = 8,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic                      center_mode,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       polarity,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      update_pending
);

  logic [PRESCALE_WIDTH-1:0] presc_r, presc_next_s;
  logic [WIDTH-1:0]          cnt_r, cnt_next_s;
  logic                      dir_down_r, dir_next_s;
  logic                      tick_s, boundary_s, apply_s;
  logic [WIDTH-1:0]          stg_period_r, act_period_r;
  logic                      stg_center_r, act_center_r;
  logic [CHANNELS*WIDTH-1:0] stg_duty_r, act_duty_r;
  logic [CHANNELS-1:0]       stg_pol_r, act_pol_r;
  logic                      pending_r;
  logic [CHANNELS-1:0]       raw_s, pwm_out_r;
  logic                      period_start_r;

  // An all-ones duty is forced high so it also covers the cnt == all-ones step.
  function automatic logic raw_level(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] c);
    return (d > c) || (&d);
  endfunction

  // Prescaler, counter and direction next-state, plus tick/boundary detection
  always_comb begin
    tick_s       = 1'b0;
    boundary_s   = 1'b0;
    presc_next_s = presc_r;
    cnt_next_s   = cnt_r;
    dir_next_s   = dir_down_r;
    if (!enable) begin
      presc_next_s = '0;
      cnt_next_s   = '0;
      dir_next_s   = 1'b0;
    end else if (presc_r >= prescale) begin
      tick_s       = 1'b1;
      presc_next_s = '0;
      if (act_center_r) begin
        if (act_period_r == '0) begin
          boundary_s = 1'b1;
          cnt_next_s = '0;
          dir_next_s = 1'b0;
        end else if (dir_down_r) begin
          if (cnt_r == '0) begin
            boundary_s = 1'b1;
            dir_next_s = 1'b0;
          end else begin
            cnt_next_s = cnt_r - WIDTH'(1);
          end
        end else if (cnt_r >= act_period_r - WIDTH'(1)) begin
          // top endpoint: hold the count for a second tick and turn around
          dir_next_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + WIDTH'(1);
        end
      end else if (cnt_r == act_period_r) begin
        boundary_s = 1'b1;
        cnt_next_s = '0;
        dir_next_s = 1'b0;
      end else begin
        cnt_next_s = cnt_r + WIDTH'(1);
      end
    end else begin
      presc_next_s = presc_r + PRESCALE_WIDTH'(1);
    end
    apply_s = pending_r && (boundary_s || !enable);
  end

  // Per-channel compare against the active duty set
  always_comb begin
    raw_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw_s[i] = raw_level(act_duty_r[i*WIDTH +: WIDTH], cnt_r);
    end
  end

  // Time base state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r    <= '0;
      cnt_r      <= '0;
      dir_down_r <= 1'b0;
    end else begin
      presc_r    <= presc_next_s;
      cnt_r      <= cnt_next_s;
      dir_down_r <= dir_next_s;
    end
  end

  // Staging/active register sets; a same-cycle apply uses the staging contents before the load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_period_r <= '1;
      stg_center_r <= 1'b0;
      stg_duty_r   <= '0;
      stg_pol_r    <= '0;
      act_period_r <= '1;
      act_center_r <= 1'b0;
      act_duty_r   <= '0;
      act_pol_r    <= '0;
      pending_r    <= 1'b0;
    end else begin
      if (apply_s) begin
        act_period_r <= stg_period_r;
        act_center_r <= stg_center_r;
        act_duty_r   <= stg_duty_r;
        act_pol_r    <= stg_pol_r;
      end
      if (load) begin
        stg_period_r <= period;
        stg_center_r <= center_mode;
        stg_duty_r   <= duty;
        stg_pol_r    <= polarity;
        pending_r    <= 1'b1;
      end else if (apply_s) begin
        pending_r    <= 1'b0;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out_r      <= '0;
      period_start_r <= 1'b0;
    end else begin
      pwm_out_r      <= enable ? (raw_s ^ act_pol_r) : act_pol_r;
      period_start_r <= tick_s && (cnt_r == '0) && !dir_down_r;
    end
  end

  assign pwm_out        = pwm_out_r;
  assign period_start   = period_start_r;
  assign update_pending = pending_r;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: expected per-cycle outputs are queued with the stimulus
// and popped/compared one cycle at a time.
module tb_pwm_multi;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int PW = 8;

  logic          clk         = 1'b0;
  logic          reset_n     = 1'b1;
  logic          enable      = 1'b0;
  logic [PW-1:0] prescale    = '0;
  logic [W-1:0]  period      = '0;
  logic          center_mode = 1'b0;
  logic [CH*W-1:0] duty      = '0;
  logic [CH-1:0] polarity    = '0;
  logic          load        = 1'b0;
  logic [CH-1:0] pwm_out;
  logic          period_start;
  logic          update_pending;

  typedef struct {
    string         tag;
    logic [CH-1:0] pwm;
    logic          ps;
    logic          pend;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .prescale(prescale),
    .period(period), .center_mode(center_mode), .duty(duty), .polarity(polarity),
    .load(load), .pwm_out(pwm_out), .period_start(period_start),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [CH-1:0] p, input logic ps, input logic pend);
    exp_t e;
    e.tag = tag; e.pwm = p; e.ps = ps; e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      step();
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_pwm"},  32'(pwm_out),        32'(e.pwm));
        chk({e.tag, "_ps"},   32'(period_start),   32'(e.ps));
        chk({e.tag, "_pend"}, 32'(update_pending), 32'(e.pend));
      end
    end
  endtask

  // Load new settings while idle: first cycle captures staging, second applies it.
  task automatic config_idle(input logic [W-1:0] p, input logic c, input logic [CH*W-1:0] d,
                             input logic [CH-1:0] pol, input logic [CH-1:0] old_pol);
    enable = 1'b0; period = p; center_mode = c; duty = d; polarity = pol; load = 1'b1;
    push("idle_load", old_pol, 1'b0, 1'b1);
    drain(1);
    load = 1'b0;
    push("idle_apply", old_pol, 1'b0, 1'b0);
    drain(1);
  endtask

  initial begin
    int dd;
    int cnt;
    // reset state
    #1 reset_n = 1'b0;
    #2;
    chk("rst_pwm",  32'(pwm_out),        32'h0);
    chk("rst_ps",   32'(period_start),   32'h0);
    chk("rst_pend", 32'(update_pending), 32'h0);
    step(); step();
    reset_n = 1'b1;

    // edge mode, P=9, duty0=3
    config_idle(8'd9, 1'b0, 32'd3, 4'b0000, 4'b0000);
    enable = 1'b1;
    for (int k = 0; k < 34; k++) push("edge10", 4'((k % 10) < 3), (k % 10) == 0, 1'b0);
    drain(34);

    // mid-period load of duty0=7 at cnt=4
    duty = 32'd7; load = 1'b1;
    push("midload", 4'b0000, 1'b0, 1'b1);
    drain(1);
    load = 1'b0;
    for (int k = 35; k < 50; k++) begin
      dd = (k < 40) ? 3 : 7;
      push("midload", 4'((k % 10) < dd), (k % 10) == 0, (k <= 38));
    end
    drain(15);

    // center mode, P=4, duty0=1 then duty0=4
    config_idle(8'd4, 1'b1, 32'd1, 4'b0000, 4'b0000);
    enable = 1'b1;
    for (int k = 0; k < 16; k++) push("center", 4'(((k % 8) == 0) || ((k % 8) == 7)), (k % 8) == 0, 1'b0);
    drain(16);
    duty = 32'd4; load = 1'b1;
    push("center_load", 4'b0001, 1'b1, 1'b1);
    drain(1);
    load = 1'b0;
    for (int k = 17; k < 40; k++) begin
      if (k < 24) push("center_d1", 4'(((k % 8) == 0) || ((k % 8) == 7)), (k % 8) == 0, (k <= 22));
      else        push("center_d4", 4'b0001, (k % 8) == 0, 1'b0);
    end
    drain(23);

    // prescale=2, edge, P=3, duty0=2
    prescale = 8'd2;
    config_idle(8'd3, 1'b0, 32'd2, 4'b0000, 4'b0000);
    enable = 1'b1;
    for (int j = 0; j < 24; j++) push("presc", 4'(((j / 3) % 4) < 2), (j % 12) == 2, 1'b0);
    drain(24);

    // extremes and polarity, P=255
    prescale = 8'd0;
    config_idle(8'd255, 1'b0, {8'd255, 8'd255, 8'd100, 8'd0}, 4'b0010, 4'b0000);
    push("idle_pol", 4'b0010, 1'b0, 1'b0);
    drain(1);
    enable = 1'b1;
    for (int j = 0; j < 260; j++) begin
      cnt = j % 256;
      push("extreme", {1'b1, 1'b1, !(cnt < 100), 1'b0}, cnt == 0, 1'b0);
    end
    drain(260);

    // asynchronous reset mid-period with a load pending
    duty = 32'd50; load = 1'b1;
    step();
    chk("pre_rst_pend", 32'(update_pending), 32'h1);
    load = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_pwm",  32'(pwm_out),        32'h0);
    chk("midrst_ps",   32'(period_start),   32'h0);
    chk("midrst_pend", 32'(update_pending), 32'h0);
    step(); step();
    reset_n = 1'b1;
    for (int j = 0; j < 258; j++) push("post_rst", 4'b0000, (j % 256) == 0, 1'b0);
    drain(258);

    // load coinciding with a boundary
    config_idle(8'd3, 1'b0, 32'd2, 4'b0000, 4'b0000);
    enable = 1'b1;
    push("coinc", 4'b0001, 1'b1, 1'b0);
    drain(1);
    duty = 32'd1; load = 1'b1;
    push("coinc", 4'b0001, 1'b0, 1'b1);
    drain(1);
    load = 1'b0;
    push("coinc", 4'b0000, 1'b0, 1'b1);
    drain(1);
    duty = 32'd3; load = 1'b1;
    push("coinc_bnd", 4'b0000, 1'b0, 1'b1);
    drain(1);
    load = 1'b0;
    for (int j = 4; j < 12; j++) begin
      dd = (j < 8) ? 1 : 3;
      push("coinc_after", 4'((j % 4) < dd), (j % 4) == 0, (j <= 6));
    end
    drain(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
